mem_responder: RTL and testbench

Memory-side responder for the multicycle core's data/instruction bus. It accepts one word-oriented read or write request at a time from the control/datapath initiator and performs it on an internal synchronous word RAM, applying byte strobes and a configurable number of wait states. Each request gets exactly one response, which carries read data or an error flag and is held until the initiator accepts it. It replaces the direct RAM hookup where the initiator must tolerate variable memory latency.

---
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-RAM bus responder: one request at a time, configurable wait states, held response.
// Latency: valid request responds WAIT_STATES+1 cycles after accept; errors respond the next cycle.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic accept;
  logic addr_bad;

  assign accept   = req_valid && req_ready;
  assign addr_bad = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (accept) begin
          if (addr_bad) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        if (addr_bad) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end
      end
      // Read data lands in the response register as the FSM enters RESP.
      if (state_q == ACCESS) begin
        err_q   <= 1'b0;
        rdata_q <= we_q ? 32'd0 : mem_q[idx_q];
      end
    end
  end

  // RAM is deliberately not reset; write enable is gated by rst.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a word-array reference model and directed plan cases.
module tb_mem_responder;
  localparam int ADDR_W = 10;
  localparam int W      = 1;
  localparam int NWORDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] ref_mem [NWORDS];

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One complete transaction; hold keeps rsp_ready low that many cycles, pulse injects a stray request.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, input bit pulse);
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic        got_err;
    int          idx;
    int          lat;
    exp_err = (addr % 4 != 0) || (addr >= 32'h1000);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      idx = int'(addr / 4);
      if (we) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) ref_mem[idx][8*l +: 8] = wdata[8*l +: 8];
      end else begin
        exp_rd = ref_mem[idx];
      end
    end
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), exp_err ? 32'd0 : 32'(W + 1));
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    got_rd  = rsp_rdata;
    got_err = rsp_err;
    for (int k = 0; k < hold; k++) begin
      if (pulse && k == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = $urandom; req_be = 4'hF;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, got_rd);
      chk("bp_err", {31'd0, rsp_err}, {31'd0, got_err});
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h020; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    bit          we;
    int          sel;
    int          hold;
    logic [31:0] addr;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_be = 4'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NWORDS; i++) txn(1'b1, 32'(i * 4), 32'd0, 4'hF, 0, 1'b0);

    txn(1'b1, 32'h010, 32'hDEADBEEF, 4'b1111, 0, 1'b0);
    txn(1'b0, 32'h010, 32'd0, 4'b0000, 0, 1'b0);
    txn(1'b1, 32'h010, 32'h0000AA00, 4'b0010, 0, 1'b0);
    txn(1'b0, 32'h010, 32'd0, 4'b1111, 0, 1'b0);
    txn(1'b1, 32'h010, 32'h55555555, 4'b0000, 0, 1'b0);
    txn(1'b0, 32'h010, 32'd0, 4'b0000, 0, 1'b0);
    txn(1'b0, 32'h013, 32'd0, 4'b0000, 0, 1'b0);
    txn(1'b0, 32'h010, 32'd0, 4'b0000, 0, 1'b0);
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, 0, 1'b0);
    txn(1'b0, 32'h000, 32'd0, 4'b0000, 0, 1'b0);
    txn(1'b0, 32'h010, 32'd0, 4'b0000, 5, 1'b1);
    txn(1'b0, 32'h000, 32'd0, 4'b0000, 0, 1'b0);
    reset_in_wait();
    txn(1'b0, 32'h020, 32'd0, 4'b0000, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom);
      sel  = int'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, NWORDS - 1)) * 4;
      if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = 32'h1000 | $urandom;
      hold = int'($urandom_range(0, 3));
      txn(we, addr, $urandom, 4'($urandom), hold, (hold >= 2) && ($urandom % 2 == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
